// File: rtl/row_prog_loader.sv
// Byte-serial program loader for a four-core row: assembles an image in a shadow buffer,
// commits it atomically and then holds the cores in reset. Optional checksum: LOADER_CHECKSUM_EN.
module row_prog_loader #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  pLength [0:3],
  output logic [15:0] prog [0:59],
  output logic        core_rst,
  output logic        loaded,
  output logic        frame_ok,
  output logic        frame_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_INSTR_HI, S_INSTR_LO, S_CSUM, S_COMMIT, S_ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_INSTR_HI, S_INSTR_LO, S_COMMIT, S_ABORT
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic        r_in_ready;
  logic        r_frame_ok;
  logic        r_frame_err;
  logic        w_ready_next;
  logic        w_ok_next;
  logic        w_err_next;

  logic [3:0]  r_sh_len [0:3];
  logic [15:0] r_sh_prog [0:59];
  logic [1:0]  r_len_idx;
  logic [5:0]  r_word_idx;
  logic [3:0]  r_plen [0:3];
  logic [15:0] r_prog [0:59];
  logic        r_loaded;
  logic        r_core_rst;
  logic [7:0]  r_rst_cnt;
  logic [15:0] r_to_cnt;

  logic        w_accept;
  logic        w_in_frame;
  logic        w_timeout;
  logic        w_is_sync;
  logic        w_len_bad;

  assign w_accept  = in_valid && r_in_ready;
  assign w_is_sync = (in_data == SYNC_BYTE);
  assign w_len_bad = (in_data > 8'd15);
`ifdef LOADER_CHECKSUM_EN
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_INSTR_HI) ||
                      (r_state == S_INSTR_LO) || (r_state == S_CSUM);
`else
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_INSTR_HI) ||
                      (r_state == S_INSTR_LO);
`endif
  // An accepted byte in the timeout cycle wins over the abort.
  assign w_timeout = w_in_frame && !w_accept && (r_to_cnt == 16'(TIMEOUT - 1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running 8-bit sum over length and instruction bytes; the sync byte only clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= 8'h00;
    end else if (w_accept && (r_state == S_IDLE) && w_is_sync) begin
      r_csum <= 8'h00;
    end else if (w_accept && ((r_state == S_LEN) || (r_state == S_INSTR_HI) ||
                              (r_state == S_INSTR_LO))) begin
      r_csum <= r_csum + in_data;
    end
  end
`endif

  // State register plus the registered handshake and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= w_ready_next;
      r_frame_ok  <= w_ok_next;
      r_frame_err <= w_err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_sync) w_next_state = S_LEN;
        else                       w_next_state = S_IDLE;
      end
      S_LEN: begin
        if (w_accept) begin
          if (w_len_bad)                w_next_state = S_ABORT;
          else if (r_len_idx == 2'd3)   w_next_state = S_INSTR_HI;
          else                          w_next_state = S_LEN;
        end else if (w_timeout) begin
          w_next_state = S_ABORT;
        end else begin
          w_next_state = S_LEN;
        end
      end
      S_INSTR_HI: begin
        if (w_accept)       w_next_state = S_INSTR_LO;
        else if (w_timeout) w_next_state = S_ABORT;
        else                w_next_state = S_INSTR_HI;
      end
      S_INSTR_LO: begin
        if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (r_word_idx == 6'd59) w_next_state = S_CSUM;
`else
          if (r_word_idx == 6'd59) w_next_state = S_COMMIT;
`endif
          else                     w_next_state = S_INSTR_HI;
        end else if (w_timeout) begin
          w_next_state = S_ABORT;
        end else begin
          w_next_state = S_INSTR_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          if (in_data == r_csum) w_next_state = S_COMMIT;
          else                   w_next_state = S_ABORT;
        end else if (w_timeout) begin
          w_next_state = S_ABORT;
        end else begin
          w_next_state = S_CSUM;
        end
      end
`endif
      S_COMMIT: w_next_state = S_IDLE;
      S_ABORT:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    w_ready_next = 1'b0;
    w_ok_next    = 1'b0;
    w_err_next   = 1'b0;
    case (w_next_state)
      S_COMMIT: w_ok_next    = 1'b1;
      S_ABORT:  w_err_next   = 1'b1;
      default:  w_ready_next = 1'b1;
    endcase
  end

  // Shadow buffer and frame indices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)  r_sh_len[i]  <= 4'h0;
      for (int i = 0; i < 60; i++) r_sh_prog[i] <= 16'h0000;
      r_len_idx  <= 2'd0;
      r_word_idx <= 6'd0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_sync) begin
            r_len_idx  <= 2'd0;
            r_word_idx <= 6'd0;
          end
        end
        S_LEN: begin
          if (!w_len_bad) begin
            r_sh_len[r_len_idx] <= in_data[3:0];
            r_len_idx           <= r_len_idx + 2'd1;
          end
        end
        S_INSTR_HI: r_sh_prog[r_word_idx][15:8] <= in_data;
        S_INSTR_LO: begin
          r_sh_prog[r_word_idx][7:0] <= in_data;
          r_word_idx                 <= r_word_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Committed image, loaded flag and core reset counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)  r_plen[i] <= 4'h0;
      for (int i = 0; i < 60; i++) r_prog[i] <= 16'h0000;
      r_loaded   <= 1'b0;
      r_core_rst <= 1'b1;
      r_rst_cnt  <= 8'd0;
    end else if (r_state == S_COMMIT) begin
      r_plen     <= r_sh_len;
      r_prog     <= r_sh_prog;
      r_loaded   <= 1'b1;
      r_core_rst <= 1'b1;
      r_rst_cnt  <= 8'(RST_CYCLES);
    end else if (r_rst_cnt != 8'd0) begin
      r_rst_cnt <= r_rst_cnt - 8'd1;
      if (r_rst_cnt == 8'd1) r_core_rst <= 1'b0;
    end
  end

  // Inter-byte timeout counter, active only while inside a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= 16'd0;
    end else if (w_accept || !w_in_frame) begin
      r_to_cnt <= 16'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign in_ready  = r_in_ready;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign pLength   = r_plen;
  assign prog      = r_prog;
  assign core_rst  = r_core_rst;
  assign loaded    = r_loaded;

endmodule

// File: tb/tb_row_prog_loader.sv
// Self-checking bench for row_prog_loader: table of frames plus hand-written timeout and reset sequences.
module tb_row_prog_loader;
  localparam int TO = 16;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [3:0]  pLength [0:3];
  logic [15:0] prog [0:59];
  logic        core_rst, loaded, frame_ok, frame_err;

  row_prog_loader #(.SYNC_BYTE(8'hA5), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pLength(pLength), .prog(prog), .core_rst(core_rst), .loaded(loaded),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:3][7:0] lens;
    logic [15:0]     base;
    int              junk;
    int              ncut;
    int              delta;
    bit              exp_ok;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  bit          sb[$];
  logic [7:0]  fb[$];
  logic [3:0]  m_len [0:3];
  logic [15:0] m_prog [0:59];
  vec_t        vecs[$];

  function automatic vec_t mk(input logic [0:3][7:0] l, input logic [15:0] b,
                              input int j, input int n, input int d, input bit ok);
    vec_t v;
    v.lens = l; v.base = b; v.junk = j; v.ncut = n; v.delta = d; v.exp_ok = ok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; any status pulse is matched against the scoreboard.
  task automatic tick();
    bit e;
    @(posedge clk); #1;
    if (frame_ok || frame_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'd0, frame_ok, frame_err}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {62'd0, frame_ok, frame_err}, e ? 64'd2 : 64'd1);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) chk("ready_wait", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic build(input vec_t v);
    logic [7:0]  sum;
    logic [15:0] w;
    fb.delete();
    fb.push_back(8'hA5);
    sum = 8'h00;
    for (int k = 0; k < 4; k++) begin
      fb.push_back(v.lens[k]);
      sum = sum + v.lens[k];
    end
    for (int n = 0; n < 60; n++) begin
      w = v.base + 16'(n);
      fb.push_back(w[15:8]);
      fb.push_back(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    fb.push_back(sum + 8'(v.delta));
`endif
  endtask

  task automatic check_outputs(input string name);
    int bad_l, bad_p;
    bad_l = 0; bad_p = 0;
    for (int k = 0; k < 4; k++)  if (pLength[k] !== m_len[k]) bad_l++;
    for (int n = 0; n < 60; n++) if (prog[n] !== m_prog[n])   bad_p++;
    chk({name, "_plen_mismatches"}, 64'(bad_l), 64'd0);
    chk({name, "_prog_mismatches"}, 64'(bad_p), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   n;
    logic rb;
    for (int j = 0; j < v.junk; j++) send_byte(j[0] ? 8'h12 : 8'h00);
    build(v);
    n  = (v.ncut == 0) ? fb.size() : v.ncut;
    rb = core_rst;
    sb.push_back(v.exp_ok);
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    chk({name, "_ok_now"},  {63'd0, frame_ok},  {63'd0, v.exp_ok});
    chk({name, "_err_now"}, {63'd0, frame_err}, {63'd0, !v.exp_ok});
    if (v.exp_ok) begin
      for (int k = 0; k < 4; k++)  m_len[k]  = v.lens[k][3:0];
      for (int w = 0; w < 60; w++) m_prog[w] = v.base + 16'(w);
      for (int c = 1; c <= RC + 1; c++) begin
        tick();
        chk({name, "_core_rst"}, {63'd0, core_rst}, {63'd0, (c <= RC)});
        if (c == 1) chk({name, "_loaded"}, {63'd0, loaded}, 64'd1);
      end
    end else begin
      repeat (RC + 1) tick();
      chk({name, "_core_rst_kept"}, {63'd0, core_rst}, {63'd0, rb});
    end
    check_outputs(name);
  endtask

  initial begin
    int k;
    vecs.push_back(mk({8'd3, 8'd0, 8'd15, 8'd1},  16'h1000, 0, 0,  0, 1'b1));
    vecs.push_back(mk({8'd3, 8'd0, 8'd15, 8'd1},  16'h1000, 2, 0,  0, 1'b1));
    vecs.push_back(mk({8'd2, 8'd5, 8'd16, 8'd1},  16'h2000, 0, 4,  0, 1'b0));
    vecs.push_back(mk({8'd15, 8'd15, 8'd15, 8'd15}, 16'hA5A0, 0, 0, 0, 1'b1));
    vecs.push_back(mk({8'd0, 8'd0, 8'd0, 8'd0},   16'hFFE0, 1, 0,  0, 1'b1));
`ifdef LOADER_CHECKSUM_EN
    vecs.push_back(mk({8'd7, 8'd1, 8'd2, 8'd3},   16'h3000, 0, 0,  1, 1'b0));
`endif
    for (int i = 0; i < 4; i++)  m_len[i]  = 4'h0;
    for (int i = 0; i < 60; i++) m_prog[i] = 16'h0000;

    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("rst_loaded",   {63'd0, loaded},   64'd0);
    chk("rst_pulses",   {62'd0, frame_ok, frame_err}, 64'd0);
    check_outputs("rst");
    @(negedge clk); rst = 1'b1;
    tick();
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);
    chk("prog59_before", {48'd0, prog[59]}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stalled frame: abort arrives TO clocks after the last accepted byte.
    build(vecs[0]);
    sb.push_back(1'b0);
    for (int i = 0; i < 50; i++) send_byte(fb[i]);
    k = 0;
    while (!frame_err && k < 100) begin
      tick();
      k++;
    end
    chk("timeout_cycles", 64'(k), 64'(TO));
    repeat (2) tick();
    check_outputs("timeout");
    run_vec(vecs[0], "after_timeout");
    chk("prog59_value", {48'd0, prog[59]}, 64'h103B);

    // Asynchronous reset in mid-frame.
    build(vecs[3]);
    for (int i = 0; i < 70; i++) send_byte(fb[i]);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)  m_len[i]  = 4'h0;
    for (int i = 0; i < 60; i++) m_prog[i] = 16'h0000;
    chk("mid_rst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("mid_rst_loaded",   {63'd0, loaded},   64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_outputs("mid_rst");
    @(negedge clk); rst = 1'b1;
    tick();
    chk("mid_rst_core_held", {63'd0, core_rst}, 64'd1);
    run_vec(vecs[0], "after_rst");

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
